// File: rtl/lcd_hd44780_driver.sv
// HD44780 8-bit bus write engine: runs the power-on init sequence, then issues one
// timed EN strobe plus execution wait for every byte accepted over valid/ready.
module lcd_hd44780_driver #(
  parameter int unsigned PWR_WAIT_CYC   = 1000000,
  parameter int unsigned SETUP_CYC      = 4,
  parameter int unsigned PULSE_CYC      = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic       EN,
  output logic       RS,
  output logic       RW,
  output logic [7:0] data
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = max2(max2(max2(PWR_WAIT_CYC, SETUP_CYC),
                                              max2(PULSE_CYC, CMD_WAIT_CYC)),
                                         CLEAR_WAIT_CYC);
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned IDX_W   = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(5);

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    SETUP    = 3'd1,
    PULSE    = 3'd2,
    HOLD     = 3'd3,
    IDLE     = 3'd4
  } state_e;

  // Power-on command list: function set x3, display on, clear, entry mode.
  function automatic logic [7:0] init_rom(input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0, 3'd1, 3'd2: b = 8'h38;
      3'd3:             b = 8'h0C;
      3'd4:             b = 8'h01;
      default:          b = 8'h06;
    endcase
    return b;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             long_wait_c;
  logic [CNT_W-1:0] hold_last_c;

  // Clear and return-home need the long execution wait.
  assign long_wait_c = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
  assign hold_last_c = long_wait_c ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);

  // Next-state logic; cnt counts cycles already spent in the current state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    rs_d    = rs_q;
    data_d  = data_q;
    done_d  = done_q;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == CNT_W'(PWR_WAIT_CYC - 1)) begin
          state_d = SETUP;
          cnt_d   = '0;
          idx_d   = '0;
          rs_d    = 1'b0;
          data_d  = init_rom(IDX_W'(0));
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d = PULSE;
          cnt_d   = '0;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == hold_last_c) begin
          cnt_d = '0;
          if (done_q) begin
            state_d = IDLE;
          end else if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + IDX_W'(1);
            rs_d    = 1'b0;
            data_d  = init_rom(idx_q + IDX_W'(1));
            state_d = SETUP;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (in_valid && ready_q) begin
          rs_d    = in_rs;
          data_d  = in_data;
          state_d = SETUP;
        end
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
      end
    endcase

    en_d    = (state_d == PULSE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign EN        = en_q;
  assign RS        = rs_q;
  assign RW        = 1'b0;
  assign data      = data_q;
  assign in_ready  = ready_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Randomized bench for lcd_hd44780_driver: strobes and handshakes are compared with a
// write-slot timing model (slot = setup + pulse + execution wait).
module tb_lcd_hd44780_driver;

  localparam int PWR  = 100;
  localparam int SET  = 2;
  localparam int PUL  = 4;
  localparam int CMDW = 10;
  localparam int CLRW = 50;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_rs    = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_ready, init_done, EN, RS, RW;
  logic [7:0] data;

  lcd_hd44780_driver #(
    .PWR_WAIT_CYC  (PWR),
    .SETUP_CYC     (SET),
    .PULSE_CYC     (PUL),
    .CMD_WAIT_CYC  (CMDW),
    .CLEAR_WAIT_CYC(CLRW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_rs    (in_rs),
    .in_data  (in_data),
    .in_ready (in_ready),
    .init_done(init_done),
    .EN       (EN),
    .RS       (RS),
    .RW       (RW),
    .data     (data)
  );

  typedef struct {
    int         t;
    logic       rs;
    logic [7:0] d;
  } ev_t;

  ev_t        rises[$];
  ev_t        accepts[$];
  int         widths[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  logic       en_prev     = 1'b0;
  int         rise_t      = 0;
  logic       cur_rs      = 1'b0;
  logic [7:0] cur_d       = 8'h00;
  ev_t        rise_ev;
  ev_t        acc_ev;
  logic [7:0] rom [6]     = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  always #5 clk = ~clk;

  // Cycle k = interval after the k-th rising edge following reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
      acc_ev.t  = cyc + 1;
      acc_ev.rs = in_rs;
      acc_ev.d  = in_data;
      accepts.push_back(acc_ev);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (EN === 1'b1 && en_prev !== 1'b1) begin
        rise_ev.t  = cyc;
        rise_ev.rs = RS;
        rise_ev.d  = data;
        rises.push_back(rise_ev);
        rise_t = cyc;
        cur_rs = RS;
        cur_d  = data;
        vectors++;
        if (RW !== 1'b0) begin
          miscompares++;
          $display("FAIL rw_at_strobe: RW=%b, expected 0 (cycle %0d)", RW, cyc);
        end
      end
      if (EN !== 1'b1 && en_prev === 1'b1) widths.push_back(cyc - rise_t);
      if (EN === 1'b1 && (RS !== cur_rs || data !== cur_d)) begin
        vectors++;
        miscompares++;
        $display("FAIL bus_stable: RS/data=%b/%h, expected %b/%h while EN high (cycle %0d)",
                 RS, data, cur_rs, cur_d, cyc);
      end
      en_prev = EN;
    end else begin
      en_prev = 1'b0;
    end
  end

  function automatic int slot_len(input logic rs, input logic [7:0] d);
    int wait_c;
    wait_c = (rs == 1'b0 && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? CLRW : CMDW;
    return SET + PUL + wait_c;
  endfunction

  function automatic int init_end();
    int t;
    t = PWR;
    for (int i = 0; i < 6; i++) t += slot_len(1'b0, rom[i]);
    return t;
  endfunction

  task automatic clear_logs();
    rises.delete();
    accepts.delete();
    widths.delete();
  endtask

  task automatic do_reset(input logic keep_valid);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = keep_valid;
    repeat (3) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ready_timeout: in_ready=%b after %0d cycles, expected 1", tag, in_ready, n);
    end
  endtask

  // Called right after reset release with in_valid low.
  task automatic check_init(input string tag);
    int first_done, first_ready, early, t;
    first_done  = -1;
    first_ready = -1;
    early       = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (first_done < 0 && init_done === 1'b1) first_done = cyc;
      if (first_ready < 0 && in_ready === 1'b1) first_ready = cyc;
      if (in_ready === 1'b1 && init_done !== 1'b1) early++;
    end
    vectors++;
    if (rises.size() != 6 || widths.size() != 6) begin
      miscompares++;
      $display("FAIL %s_strobe_count: rises=%0d falls=%0d, expected 6/6", tag, rises.size(), widths.size());
    end
    t = PWR;
    for (int i = 0; i < 6 && i < rises.size(); i++) begin
      vectors++;
      if (rises[i].t != t + SET || rises[i].d !== rom[i] || rises[i].rs !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_init%0d: cycle=%0d data=%h rs=%b, expected cycle=%0d data=%h rs=0",
                 tag, i, rises[i].t, rises[i].d, rises[i].rs, t + SET, rom[i]);
      end
      if (i < widths.size()) begin
        vectors++;
        if (widths[i] != PUL) begin
          miscompares++;
          $display("FAIL %s_width%0d: %0d cycles, expected %0d", tag, i, widths[i], PUL);
        end
      end
      t += slot_len(1'b0, rom[i]);
    end
    vectors++;
    if (first_done != init_end() || first_ready != init_end() || early != 0) begin
      miscompares++;
      $display("FAIL %s_done_time: init_done@%0d in_ready@%0d early=%0d, expected %0d/%0d/0",
               tag, first_done, first_ready, early, init_end(), init_end());
    end
  endtask

  task automatic write_one(input logic rs, input logic [7:0] d, input string tag);
    int a, back, nr;
    wait_ready(tag);
    nr       = rises.size();
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    a        = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_rs    = 1'($urandom);
    in_data  = 8'($urandom);
    vectors++;
    if (RS !== rs || data !== d || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_latch: RS=%b data=%h in_ready=%b, expected %b/%h/0", tag, RS, data, in_ready, rs, d);
    end
    back = -1;
    for (int i = 0; i < 200 && back < 0; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) back = cyc;
    end
    vectors++;
    if (back != a + slot_len(rs, d)) begin
      miscompares++;
      $display("FAIL %s_ready_back: cycle %0d, expected %0d", tag, back, a + slot_len(rs, d));
    end
    vectors++;
    if (rises.size() != nr + 1) begin
      miscompares++;
      $display("FAIL %s_strobes: %0d strobes, expected 1", tag, rises.size() - nr);
    end else if (rises[nr].t != a + SET || rises[nr].d !== d || rises[nr].rs !== rs || widths[$] != PUL) begin
      miscompares++;
      $display("FAIL %s_strobe: rise=%0d data=%h rs=%b width=%0d, expected %0d/%h/%b/%0d",
               tag, rises[nr].t, rises[nr].d, rises[nr].rs, widths[$], a + SET, d, rs, PUL);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    vectors++;
    if ({EN, RS, RW, data, in_ready, init_done} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_async: EN RS RW data rdy done=%b %b %b %h %b %b, expected all 0",
               EN, RS, RW, data, in_ready, init_done);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({EN, RS, RW, data, in_ready, init_done} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_held: EN RS RW data rdy done=%b %b %b %h %b %b, expected all 0",
               EN, RS, RW, data, in_ready, init_done);
    end
  endtask

  task automatic test_power_on();
    do_reset(1'b0);
    check_init("power_on");
  endtask

  task automatic test_single_write();
    write_one(1'b1, 8'h2B, "data_2b");
  endtask

  task automatic test_clear_timing();
    write_one(1'b0, 8'h01, "clear");
    write_one(1'b0, 8'h80, "ddram_80");
    write_one(1'b0, 8'h02, "home_02");
    write_one(1'b0, 8'h03, "home_03");
    write_one(1'b1, 8'h01, "char_01");
    write_one(1'b0, 8'h04, "entry_04");
  endtask

  task automatic test_random_writes();
    logic       rs;
    logic [7:0] d;
    for (int i = 0; i < 10; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      write_one(rs, d, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sd [21];
    logic       sr [21];
    int         ab, rb, idx;
    sd[0] = 8'h80; sr[0] = 1'b0;
    sd[1] = 8'h2D; sr[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sd[2 + i] = 8'h30 + 8'(i);
      sr[2 + i] = 1'b1;
    end
    sd[12] = 8'h38; sr[12] = 1'b0;
    sd[13] = 8'hC0; sr[13] = 1'b0;
    for (int i = 14; i < 21; i++) begin
      sr[i] = 1'($urandom_range(0, 1));
      sd[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
    end
    wait_ready("b2b_start");
    ab       = accepts.size();
    rb       = rises.size();
    idx      = 0;
    in_valid = 1'b1;
    in_rs    = sr[0];
    in_data  = sd[0];
    for (int c = 0; c < 3000 && idx < 21; c++) begin
      @(negedge clk);
      if (accepts.size() > ab + idx) begin
        idx++;
        if (idx < 21) begin
          in_rs   = sr[idx];
          in_data = sd[idx];
        end
      end
    end
    in_valid = 1'b0;
    wait_ready("b2b_end");
    vectors++;
    if (accepts.size() - ab != 21 || rises.size() - rb != 21) begin
      miscompares++;
      $display("FAIL b2b_count: accepted=%0d strobed=%0d, expected 21/21", accepts.size() - ab, rises.size() - rb);
    end else begin
      for (int i = 0; i < 21; i++) begin
        vectors++;
        if (accepts[ab + i].d !== sd[i] || accepts[ab + i].rs !== sr[i] ||
            rises[rb + i].d !== sd[i] || rises[rb + i].rs !== sr[i] ||
            rises[rb + i].t != accepts[ab + i].t + SET) begin
          miscompares++;
          $display("FAIL b2b_byte%0d: strobe %h/%b@%0d, expected %h/%b@%0d",
                   i, rises[rb + i].d, rises[rb + i].rs, rises[rb + i].t, sd[i], sr[i], accepts[ab + i].t + SET);
        end
        if (i > 0) begin
          vectors++;
          if (accepts[ab + i].t != accepts[ab + i - 1].t + slot_len(sr[i - 1], sd[i - 1]) + 1) begin
            miscompares++;
            $display("FAIL b2b_gap%0d: accept@%0d, expected %0d", i, accepts[ab + i].t,
                     accepts[ab + i - 1].t + slot_len(sr[i - 1], sd[i - 1]) + 1);
          end
        end
      end
    end
  endtask

  task automatic test_early_valid();
    logic [7:0] b;
    int         n;
    b       = 8'($urandom);
    in_rs   = 1'b1;
    in_data = b;
    do_reset(1'b1);
    n = 0;
    while (accepts.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    wait_ready("early");
    vectors++;
    if (accepts.size() != 1 || accepts[0].t != init_end() + 1) begin
      miscompares++;
      $display("FAIL early_accept: %0d accepts, first@%0d, expected 1 @%0d",
               accepts.size(), (accepts.size() > 0) ? accepts[0].t : -1, init_end() + 1);
    end
    vectors++;
    if (rises.size() != 7) begin
      miscompares++;
      $display("FAIL early_strobes: %0d strobes, expected 7", rises.size());
    end else if (rises[5].d !== 8'h06 || rises[6].d !== b || rises[6].rs !== 1'b1 ||
                 rises[6].t != init_end() + 1 + SET) begin
      miscompares++;
      $display("FAIL early_7th: %h/%b@%0d (6th=%h), expected %h/1@%0d (6th=06)",
               rises[6].d, rises[6].rs, rises[6].t, rises[5].d, b, init_end() + 1 + SET);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    wait_ready("midrst");
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (EN !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (EN !== 1'b0 || in_ready !== 1'b0 || init_done !== 1'b0 || data !== 8'h00 || RS !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: EN=%b rdy=%b done=%b RS=%b data=%h (EN seen after %0d), expected all 0",
               EN, in_ready, init_done, RS, data, n);
    end
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    check_init("after_midrst");
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_single_write();
    test_clear_timing();
    test_random_writes();
    test_back_to_back();
    test_early_valid();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
